// File: rtl/pdm_decimator_pkg.sv
// -----------------------------------------------------------------------------
// pdm_decimator_pkg
// Shared constants for the PDM receive path (sinc^2 decimator).
//   AUDIO_BITS     : PCM sample width shared with the synth mixer and the DAC.
//   LOG2_R_DEFAULT : log2 of the decimation ratio (128 bits per sample).
//   PRIME_DISCARD  : number of comb results thrown away after reset while the
//                    comb delay lines fill with meaningful history.
//   cic_width()    : datapath width of a 2nd-order CIC with ratio 2**log2_r.
// -----------------------------------------------------------------------------
package pdm_decimator_pkg;

    localparam int AUDIO_BITS     = 13;
    localparam int LOG2_R_DEFAULT = 7;

    localparam logic [1:0] PRIME_DISCARD = 2'd2;

    // Peak sinc^2 gain is R^2 = 2^(2*log2_r); one extra bit keeps that value
    // representable, so the modular integrator arithmetic cancels exactly.
    function automatic int cic_width(input int log2_r);
        return 2 * log2_r + 1;
    endfunction

endpackage

// File: rtl/pdm_decimator_cic2_core.sv
// -----------------------------------------------------------------------------
// pdm_decimator_cic2_core
// Second-order CIC decimator: two integrators running at the bit rate, two
// combs running once per frame of R accepted bits, priming gate, and scaling
// with saturation down to OUT_BITS.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   pdm_i        : bitstream bit, taken when pdm_valid_i = 1
//   pdm_valid_i  : bit strobe; all state holds while low
//   y_o          : scaled, saturated sample (valid while y_valid_o = 1)
//   y_valid_o    : one-cycle strobe, first asserted on the 3rd decimation
// -----------------------------------------------------------------------------
module pdm_decimator_cic2_core
    import pdm_decimator_pkg::*;
#(
    parameter int LOG2_R   = LOG2_R_DEFAULT,
    parameter int OUT_BITS = AUDIO_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pdm_i,
    input  logic                pdm_valid_i,
    output logic [OUT_BITS-1:0] y_o,
    output logic                y_valid_o
);

    localparam int W     = cic_width(LOG2_R);
    // OUT_BITS must not exceed 2*LOG2_R, so this is never negative.
    localparam int SHIFT = 2 * LOG2_R - OUT_BITS;

    localparam logic [LOG2_R-1:0] CNT_LAST = {LOG2_R{1'b1}};
    localparam logic [W-1:0]      Y_MAX    = W'((1 << OUT_BITS) - 1);

    // Integrator section (bit rate)
    logic [W-1:0]      i1_q, i1_d;
    logic [W-1:0]      i2_q, i2_d;
    logic [LOG2_R-1:0] cnt_q, cnt_d;
    logic              tick_q, tick_d;

    // Comb section (frame rate)
    logic [W-1:0]      i2_dly_q, i2_dly_d;
    logic [W-1:0]      c1_dly_q, c1_dly_d;
    logic [W-1:0]      cic_q, cic_d;
    logic [W-1:0]      c1, c2;
    logic [1:0]        prime_q, prime_d;
    logic              out_tick_q, out_tick_d;

    logic [W-1:0]      scaled;

    // -------------------------------------------------------------------------
    // Integrators and bit counter. Wrap-around is intentional: the combs see
    // differences only, which are exact modulo 2^W.
    // -------------------------------------------------------------------------
    always_comb begin
        i1_d   = i1_q;
        i2_d   = i2_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (pdm_valid_i) begin
            i1_d   = i1_q + W'(pdm_i);
            i2_d   = i2_q + i1_q;               // old i1 on purpose
            cnt_d  = cnt_q + LOG2_R'(1);        // natural wrap at R-1
            tick_d = (cnt_q == CNT_LAST);
        end
    end

    // -------------------------------------------------------------------------
    // Comb stage, evaluated the cycle after the last bit of a frame lands in
    // i2. The prime counter swallows the first results while the delay
    // registers still hold reset zeros instead of real history.
    // -------------------------------------------------------------------------
    always_comb begin
        c1 = i2_q - i2_dly_q;
        c2 = c1 - c1_dly_q;

        i2_dly_d   = i2_dly_q;
        c1_dly_d   = c1_dly_q;
        cic_d      = cic_q;
        prime_d    = prime_q;
        out_tick_d = 1'b0;
        if (tick_q) begin
            i2_dly_d = i2_q;
            c1_dly_d = c1;
            cic_d    = c2;
            if (prime_q != PRIME_DISCARD) begin
                prime_d = prime_q + 2'd1;
            end else begin
                out_tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i1_q       <= '0;
            i2_q       <= '0;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            i2_dly_q   <= '0;
            c1_dly_q   <= '0;
            cic_q      <= '0;
            prime_q    <= '0;
            out_tick_q <= 1'b0;
        end else begin
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            i2_dly_q   <= i2_dly_d;
            c1_dly_q   <= c1_dly_d;
            cic_q      <= cic_d;
            prime_q    <= prime_d;
            out_tick_q <= out_tick_d;
        end
    end

    // -------------------------------------------------------------------------
    // Scaling. The comb output spans 0..R^2; an all-ones stream hits exactly
    // R^2, which after the shift is one above full scale and must clamp to
    // all-ones rather than wrap to zero.
    // -------------------------------------------------------------------------
    always_comb begin
        scaled = cic_q >> SHIFT;
        if (scaled > Y_MAX) begin
            y_o = Y_MAX[OUT_BITS-1:0];
        end else begin
            y_o = scaled[OUT_BITS-1:0];
        end
    end

    assign y_valid_o = out_tick_q;

endmodule

// File: rtl/pdm_decimator.sv
// -----------------------------------------------------------------------------
// pdm_decimator
// Receive end of the audio path: converts the 1-bit sigma-delta stream back
// into unsigned PCM with a sinc^2 decimator, and presents each sample behind a
// valid/ready register with a sticky overrun flag.
//
// Ports
//   clk, rst_n    : clock, synchronous active-low reset
//   pdm_in        : bitstream bit, sampled when pdm_valid = 1
//   pdm_valid     : bit strobe (tie high for one bit per clock)
//   sample_out    : decimated unsigned sample
//   sample_valid  : sample_out holds an unconsumed sample
//   sample_ready  : consumer accepts; transfer when valid && ready
//   overrun       : sticky, a sample was overwritten before being consumed
//   overrun_clr   : one-cycle pulse clearing overrun (a coincident new
//                   overrun takes precedence)
// -----------------------------------------------------------------------------
module pdm_decimator
    import pdm_decimator_pkg::*;
#(
    parameter int LOG2_R   = LOG2_R_DEFAULT,
    parameter int OUT_BITS = AUDIO_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pdm_in,
    input  logic                pdm_valid,
    output logic [OUT_BITS-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    logic [OUT_BITS-1:0] y;
    logic                y_valid;

    logic [OUT_BITS-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;

    pdm_decimator_cic2_core #(
        .LOG2_R   (LOG2_R),
        .OUT_BITS (OUT_BITS)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .pdm_i       (pdm_in),
        .pdm_valid_i (pdm_valid),
        .y_o         (y),
        .y_valid_o   (y_valid)
    );

    // A new sample always loads. It only counts as an overrun when the held
    // sample is neither already consumed nor leaving in this same cycle.
    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (overrun_clr) begin
            ovr_d = 1'b0;
        end
        if (y_valid) begin
            sample_d = y;
            valid_d  = 1'b1;
            if (valid_q && !sample_ready) begin
                ovr_d = 1'b1;                   // set beats clear
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule
